pool2x2_relu: RTL and testbench
===============================

# pool2x2_relu

Downstream stage of the convolution core. Consumes the core's unhandshaked output stream (data + x/y/ch coordinates) and applies optional ReLU and 2x2 stride-2 max pooling per channel. Emits one pooled value per complete window on a valid/ready stream buffered by a small FIFO. The producer cannot be stalled, so overflow is detected and flagged, never back-pressured.

## Interface
- DATA_WIDTH, 16, signed data width
- FEATURE_MAP_WIDTH, 128, input map width W; must be even (elaboration error otherwise)
- FEATURE_MAP_HEIGHT, 128, input map height H; must be even
- OUTPUT_NB_CHANNELS, 64, channel count CH
- FIFO_DEPTH, 4, output FIFO entries, power of two, >= 2
- RELU, 1, 1: clamp pooled result to >= 0; 0: pass-through
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse at start of a layer; clears overflow
- in_data  in  DATA_WIDTH  signed conv output
- in_valid  in  1  in_* valid this cycle; always accepted
- in_x  in  $clog2(W)  column
- in_y  in  $clog2(H)  row
- in_ch  in  $clog2(CH)  channel
- pool_data  out  DATA_WIDTH  signed pooled value
- pool_valid  out  1  FIFO non-empty
- pool_ready  in  1  consumer accepts
- pool_x  out  $clog2(W)-1  pooled column (in_x>>1)
- pool_y  out  $clog2(H)-1  pooled row (in_y>>1)
- pool_ch  out  $clog2(CH)  channel
- overflow  out  1  sticky: a pooled value was dropped

## Operation
- Required input ordering: within any window (2i..2i+1, 2j..2j+1, ch), element (even x, even y) arrives first and (odd x, odd y) last; windows sharing index (i, ch) never interleave. Raster order with y outermost satisfies this.
- Partial-max buffer: (W/2)*CH entries of DATA_WIDTH; index = (in_x>>1)*CH + in_ch.
- On in_valid, with b = buffer[index]:
  - x even, y even: write in_data (initialise).
  - otherwise: m = signed max(b, in_data); write m.
  - x odd, y odd: result = m, or max(m, 0) if RELU; push {result, x>>1, y>>1, ch} into FIFO. The buffer write is don't-care.
- Comparison is signed, full DATA_WIDTH; no widening, no rounding.
- FIFO: push as above; pop when pool_valid && pool_ready. pool_* show the head entry.
- Push with FIFO full and no pop in the same cycle: entry dropped, FIFO unchanged, overflow <= 1.
- Push and pop in the same cycle while full: both happen, occupancy unchanged, no overflow.
- overflow clears on rst or start. A start coinciding with a new drop leaves overflow = 1.
- start does not flush the FIFO or buffer. The buffer needs no clearing because every window initialises on its (even, even) element.

## Timing
- Reset values:
  - pool_valid = 0
  - overflow = 0
  - FIFO pointers and count = 0
  - pool_data/x/y/ch = 0
  - buffer contents undefined (not reset)
- Buffer is read combinationally and written on the same edge. Back-to-back in_valid to the same index (different x/y in one window) must see the value written on the previous edge.
- Latency: the (odd, odd) input sampled at edge n is visible on pool_* with pool_valid = 1 after edge n, provided the FIFO was empty.
- Sustained throughput: 1 input per cycle, 1 pop per cycle.
- rst mid-layer: FIFO emptied and overflow cleared on that edge. in_valid is ignored while rst = 1. Windows in progress are lost; the producer restarts the layer.

## Test plan
- Basic window: W=H=4, CH=1, RELU=0. Feed window (0,0)..(1,1) = 3, -7, 12, 5 in raster order -> one output 12 at pool_x=0, pool_y=0, one cycle after the (1,1) sample.
- ReLU: RELU=1, window values -4, -9, -1, -2 -> pool_data = 0. Same window with RELU=0 -> -1. Include -32768 and 32767 to confirm signed comparison.
- Full map: W=H=8, CH=4, random data in raster order, pool_ready held at 1 -> exactly 64 outputs matching a reference model. Coordinates cover all (0..3, 0..3, 0..3). overflow stays 0.
- Overflow: FIFO_DEPTH=4, pool_ready=0, 5 windows complete -> 4 entries held, fifth dropped, overflow=1. Pulse start -> overflow=0. Drain -> the first 4 values in order.
- Full plus simultaneous push/pop: FIFO full, pool_ready=1 on the cycle of a completing window -> occupancy stays 4, new value at the tail, overflow=0.
- Reset mid-layer: assert rst for 1 cycle with 3 entries queued and windows partially accumulated -> next cycle pool_valid=0, overflow=0. A new layer then produces correct values with no stale data.

Source files
------------

// File: rtl/pool2x2_relu.sv
// 2x2 stride-2 max pooling with optional ReLU on an unstallable conv output stream.
// Pooled results leave through a small valid/ready FIFO; a full FIFO drops the result and flags overflow.
module pool2x2_relu #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 4,
  parameter int RELU               = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic                                  in_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] in_ch,
  output logic [DATA_WIDTH-1:0]                 pool_data,
  output logic                                  pool_valid,
  input  logic                                  pool_ready,
  output logic [$clog2(FEATURE_MAP_WIDTH)-2:0]  pool_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-2:0] pool_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] pool_ch,
  output logic                                  overflow
);

  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW  = $clog2(OUTPUT_NB_CHANNELS);
  localparam int NB  = (FEATURE_MAP_WIDTH / 2) * OUTPUT_NB_CHANNELS;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW  = DATA_WIDTH + (XW - 1) + (YW - 1) + CW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  generate
    if (FEATURE_MAP_WIDTH % 2 != 0) begin : g_bad_width
      $error("pool2x2_relu: FEATURE_MAP_WIDTH must be even");
    end
    if (FEATURE_MAP_HEIGHT % 2 != 0) begin : g_bad_height
      $error("pool2x2_relu: FEATURE_MAP_HEIGHT must be even");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pool2x2_relu: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // Partial-max buffer: one running maximum per (pooled column, channel).
  logic [DATA_WIDTH-1:0] buf_mem [NB];
  logic [IW-1:0]         idx;
  logic signed [DATA_WIDTH-1:0] buf_q;
  logic signed [DATA_WIDTH-1:0] din;
  logic signed [DATA_WIDTH-1:0] max_v;
  logic signed [DATA_WIDTH-1:0] result;
  logic                  first_elem;
  logic                  last_elem;
  logic                  accept;

  assign idx        = IW'(int'(in_x[XW-1:1]) * OUTPUT_NB_CHANNELS + int'(in_ch));
  assign buf_q      = $signed(buf_mem[idx]);
  assign din        = $signed(in_data);
  assign max_v      = (din > buf_q) ? din : buf_q;
  assign result     = ((RELU != 0) && max_v[DATA_WIDTH-1]) ? '0 : max_v;
  assign first_elem = ~in_x[0] & ~in_y[0];
  assign last_elem  = in_x[0] & in_y[0];
  assign accept     = in_valid & ~rst;

  // Buffer is deliberately left unreset: every window initialises on its (even, even) element.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[idx] <= first_elem ? in_data : max_v;
    end
  end

  // Valid/ready: an entry transfers on a rising edge where pool_valid and pool_ready are both high;
  // pool_valid never depends on pool_ready, and the head stays stable until it is taken.
  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic [EW-1:0]         push_entry;
  logic [DATA_WIDTH-1:0] hd_data;
  logic [XW-2:0]         hd_x;
  logic [YW-2:0]         hd_y;
  logic [CW-1:0]         hd_ch;

  assign push       = accept & last_elem;
  assign pool_valid = (count != '0);
  assign pop        = pool_valid & pool_ready;
  assign full       = (count == FULL_CNT);
  assign push_ok    = push & (~full | pop);
  assign push_entry = {result, in_x[XW-1:1], in_y[YW-1:1], in_ch};

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (!push_ok && pop) begin
        count <= count - (AW+1)'(1);
      end
      // A drop on the same edge as start wins so the loss is never hidden.
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (start) begin
        overflow <= 1'b0;
      end
    end
  end

  assign {hd_data, hd_x, hd_y, hd_ch} = fifo_mem[rd_ptr];

  // Outputs read as zero while empty so they do not expose stale FIFO slots.
  assign pool_data = pool_valid ? hd_data : '0;
  assign pool_x    = pool_valid ? hd_x    : '0;
  assign pool_y    = pool_valid ? hd_y    : '0;
  assign pool_ch   = pool_valid ? hd_ch   : '0;

endmodule

// File: tb/tb_pool2x2_relu.sv
// Bench for pool2x2_relu: a RELU=1 and a RELU=0 instance share one input stream,
// each with its own expected queue checked by a monitor on the falling edge.
module tb_pool2x2_relu;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CH = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [2:0]    in_x;
  logic [2:0]    in_y;
  logic [1:0]    in_ch;
  logic          pool_ready;

  logic [DW-1:0] r_data, n_data;
  logic          r_valid, n_valid;
  logic [1:0]    r_x, r_y, r_ch, n_x, n_y, n_ch;
  logic          r_ovf, n_ovf;

  logic [21:0] exp_r[$];
  logic [21:0] exp_n[$];
  int tests = 0;
  int fails = 0;
  int cnt_r = 0;
  int cnt_n = 0;
  int img [H][W][CH];

  always #5 clk = ~clk;

  pool2x2_relu #(.DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
                 .OUTPUT_NB_CHANNELS(CH), .FIFO_DEPTH(FD), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .pool_data(r_data), .pool_valid(r_valid),
    .pool_ready(pool_ready), .pool_x(r_x), .pool_y(r_y), .pool_ch(r_ch), .overflow(r_ovf)
  );

  pool2x2_relu #(.DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
                 .OUTPUT_NB_CHANNELS(CH), .FIFO_DEPTH(FD), .RELU(0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .pool_data(n_data), .pool_valid(n_valid),
    .pool_ready(pool_ready), .pool_x(n_x), .pool_y(n_y), .pool_ch(n_ch), .overflow(n_ovf)
  );

  function automatic logic [21:0] pk(input int d, input int i, input int j, input int c);
    return {16'(d), 2'(i), 2'(j), 2'(c)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an entry is consumed on the edge following a falling edge with valid && ready.
  always @(negedge clk) begin
    logic [21:0] got;
    logic [21:0] e;
    if (!rst) begin
      if (r_valid && pool_ready) begin
        got = {r_data, r_x, r_y, r_ch};
        tests++;
        cnt_r++;
        if (exp_r.size() == 0) begin
          fails++;
          $display("FAIL out_relu: got %h but nothing expected", got);
        end else begin
          e = exp_r.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL out_relu: got %h expected %h", got, e);
          end
        end
      end
      if (n_valid && pool_ready) begin
        got = {n_data, n_x, n_y, n_ch};
        tests++;
        cnt_n++;
        if (exp_n.size() == 0) begin
          fails++;
          $display("FAIL out_pass: got %h but nothing expected", got);
        end else begin
          e = exp_n.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL out_pass: got %h expected %h", got, e);
          end
        end
      end
    end
  end

  // Drivers start and end 1 time unit after a rising edge.
  task automatic send(input int x, input int y, input int c, input int d);
    in_x     = 3'(x);
    in_y     = 3'(y);
    in_ch    = 2'(c);
    in_data  = 16'(d);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic win(input int i, input int j, input int c,
                     input int d0, input int d1, input int d2, input int d3,
                     input int er, input int en, input bit keep, input bit rdy_last);
    send(2*i,   2*j,   c, d0);
    send(2*i+1, 2*j,   c, d1);
    send(2*i,   2*j+1, c, d2);
    if (keep) begin
      exp_r.push_back(pk(er, i, j, c));
      exp_n.push_back(pk(en, i, j, c));
    end
    if (rdy_last) pool_ready = 1'b1;
    send(2*i+1, 2*j+1, c, d3);
    if (rdy_last) pool_ready = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 100 && (exp_r.size() != 0 || exp_n.size() != 0); k++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_left_relu"}, 32'(exp_r.size()), 32'd0);
    check({tag, "_left_pass"}, 32'(exp_n.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, sr, sn;
    rst = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0;
    in_x = '0; in_y = '0; in_ch = '0; pool_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_r", 32'(r_valid), 32'd0);
    check("rst_valid_n", 32'(n_valid), 32'd0);
    check("rst_ovf_r", 32'(r_ovf), 32'd0);
    check("rst_ovf_n", 32'(n_ovf), 32'd0);
    check("rst_out_n", 32'({n_data, n_x, n_y, n_ch}), 32'd0);
    rst = 1'b0;
    idle(1);

    // Basic window and one-cycle latency.
    win(0, 0, 0, 3, -7, 12, 5, 12, 12, 1'b1, 1'b0);
    check("latency_valid", 32'(n_valid), 32'd1);
    check("latency_data", 32'(n_data), 32'(16'd12));
    idle(2);

    // ReLU and signed extremes, back to back.
    win(1, 0, 1, -4, -9, -1, -2, 0, -1, 1'b1, 1'b0);
    win(2, 0, 2, -32768, 32767, -1, 0, 32767, 32767, 1'b1, 1'b0);
    win(3, 0, 3, -32768, -32768, -32768, -32768, 0, -32768, 1'b1, 1'b0);
    win(0, 1, 0, 32767, -32768, 32766, -32768, 32767, 32767, 1'b1, 1'b0);
    wait_drain("directed");

    // Full map in raster order against a reference max over the four window elements.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < CH; c++)
          img[y][x][c] = int'($signed(16'($urandom_range(0, 65535))));
    sr = cnt_r;
    sn = cnt_n;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int c = 0; c < CH; c++) begin
          if ((x % 2 == 1) && (y % 2 == 1)) begin
            m = img[y-1][x-1][c];
            if (img[y-1][x][c] > m) m = img[y-1][x][c];
            if (img[y][x-1][c] > m) m = img[y][x-1][c];
            if (img[y][x][c] > m) m = img[y][x][c];
            exp_n.push_back(pk(m, x/2, y/2, c));
            exp_r.push_back(pk((m < 0) ? 0 : m, x/2, y/2, c));
          end
          send(x, y, c, img[y][x][c]);
        end
    wait_drain("fullmap");
    check("fullmap_count_r", 32'(cnt_r - sr), 32'd64);
    check("fullmap_count_n", 32'(cnt_n - sn), 32'd64);
    check("fullmap_ovf_r", 32'(r_ovf), 32'd0);
    check("fullmap_ovf_n", 32'(n_ovf), 32'd0);

    // Overflow: five windows into a four-entry FIFO with the consumer stalled.
    pool_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      win((k < 4) ? k : 0, (k < 4) ? 0 : 1, 0, k, 100 + k, -5, 1, 100 + k, 100 + k, k < 4, 1'b0);
    check("ovf_set_r", 32'(r_ovf), 32'd1);
    check("ovf_set_n", 32'(n_ovf), 32'd1);
    check("ovf_head_n", 32'(n_data), 32'(16'd100));
    start = 1'b1;
    idle(1);
    start = 1'b0;
    check("ovf_clear_r", 32'(r_ovf), 32'd0);
    check("ovf_clear_n", 32'(n_ovf), 32'd0);
    check("start_keeps_fifo", 32'(n_valid), 32'd1);
    pool_ready = 1'b1;
    wait_drain("ovf");

    // Full FIFO with a pop on the same edge as a completing window.
    pool_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      win((k < 4) ? k : 0, (k < 4) ? 0 : 1, 1, -1, 200 + k, 7, 0, 200 + k, 200 + k, 1'b1, k == 4);
    check("simul_ovf_r", 32'(r_ovf), 32'd0);
    check("simul_ovf_n", 32'(n_ovf), 32'd0);
    check("simul_head_n", 32'(n_data), 32'(16'd201));
    pool_ready = 1'b1;
    wait_drain("simul");

    // Reset mid-layer with three queued entries and a half-built window.
    pool_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      win(k, 0, 0, 300 + k, 1, 2, 3, 300 + k, 300 + k, 1'b1, 1'b0);
    send(0, 2, 1, 500);
    send(1, 2, 1, 500);
    rst = 1'b1;
    in_x = 3'd1; in_y = 3'd1; in_ch = 2'd0; in_data = 16'd999; in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_r.delete();
    exp_n.delete();
    check("midrst_valid_r", 32'(r_valid), 32'd0);
    check("midrst_valid_n", 32'(n_valid), 32'd0);
    check("midrst_ovf_r", 32'(r_ovf), 32'd0);
    check("midrst_ovf_n", 32'(n_ovf), 32'd0);
    check("midrst_data_n", 32'(n_data), 32'd0);
    pool_ready = 1'b1;
    win(0, 1, 1, -1, -2, -3, -4, 0, -1, 1'b1, 1'b0);
    win(1, 1, 1, 5, 9, -3, 2, 9, 9, 1'b1, 1'b0);
    wait_drain("newlayer");
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
